// File: rtl/cdc_fifo_pkg.sv
// rtl/cdc_fifo_pkg.sv - shared depth default, byte type and width helpers for the endpoint FIFOs
package cdc_fifo_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEPTH_DEF = 8;

  // Pointer width: pointers wrap naturally because DEPTH is a power of two
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Level width: one extra bit so the counter can hold DEPTH itself
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_fifo_ep_if.sv
// rtl/cdc_fifo_ep_if.sv - MCU-side and host-side byte handshakes of the FIFO endpoint
interface cdc_fifo_ep_if;
  import cdc_fifo_pkg::*;

  byte_t in_data_i;
  logic  in_valid_i;
  logic  in_ready_o;
  byte_t out_data_o;
  logic  out_valid_o;
  logic  out_ready_i;
  byte_t tx_data_o;
  logic  tx_valid_o;
  logic  tx_ready_i;
  byte_t rx_data_i;
  logic  rx_valid_i;
  logic  rx_ready_o;

  modport master (
    output in_data_i, in_valid_i, out_ready_i, tx_ready_i, rx_data_i, rx_valid_i,
    input  in_ready_o, out_data_o, out_valid_o, tx_data_o, tx_valid_o, rx_ready_o
  );

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i, tx_ready_i, rx_data_i, rx_valid_i,
    output in_ready_o, out_data_o, out_valid_o, tx_data_o, tx_valid_o, rx_ready_o
  );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - single-clock DEPTH x 8 FIFO with registered level and flush
module byte_fifo
  import cdc_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  byte_t                   push_data_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  output byte_t                   pop_data_o,
  output logic                    pop_valid_o,
  input  logic                    pop_ready_i,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  byte_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               push;
  logic               pop;

  // Handshake flags come only from the registered level, so ready never depends on an input
  always_comb begin
    push_ready_o = (level_q != LVL_W'(DEPTH));
    pop_valid_o  = (level_q != '0);
    pop_data_o   = mem[rd_ptr_q];
    push         = push_valid_i && push_ready_o;
    pop          = pop_ready_i && pop_valid_o;
    level_o      = level_q;
  end

  // Pointer and level bookkeeping; reset beats flush, flush beats any handshake
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; a write while flushing lands in a slot the pointers have already abandoned
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cdc_fifo_ep.sv
// rtl/cdc_fifo_ep.sv - endpoint with independent TX (MCU to host) and RX (host to MCU) byte FIFOs
module cdc_fifo_ep
  import cdc_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  cdc_fifo_ep_if.slave            bus,
  output logic [lvl_w(DEPTH)-1:0] tx_level_o,
  output logic [lvl_w(DEPTH)-1:0] rx_level_o
);

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_data_i  (bus.in_data_i),
    .push_valid_i (bus.in_valid_i),
    .push_ready_o (bus.in_ready_o),
    .pop_data_o   (bus.tx_data_o),
    .pop_valid_o  (bus.tx_valid_o),
    .pop_ready_i  (bus.tx_ready_i),
    .level_o      (tx_level_o)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_data_i  (bus.rx_data_i),
    .push_valid_i (bus.rx_valid_i),
    .push_ready_o (bus.rx_ready_o),
    .pop_data_o   (bus.out_data_o),
    .pop_valid_o  (bus.out_valid_o),
    .pop_ready_i  (bus.out_ready_i),
    .level_o      (rx_level_o)
  );

endmodule

// File: tb/tb_cdc_fifo_ep.sv
// tb/tb_cdc_fifo_ep.sv - directed self-checking bench for cdc_fifo_ep
module tb_cdc_fifo_ep;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [3:0] tx_level_o;
  logic [3:0] rx_level_o;
  int         n_checks = 0;
  int         n_fail   = 0;

  cdc_fifo_ep_if bus ();

  cdc_fifo_ep #(.DEPTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .bus        (bus.slave),
    .tx_level_o (tx_level_o),
    .rx_level_o (rx_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    bus.in_data_i    = 8'h00;
    bus.in_valid_i   = 1'b0;
    bus.out_ready_i  = 1'b0;
    bus.tx_ready_i   = 1'b0;
    bus.rx_data_i    = 8'h00;
    bus.rx_valid_i   = 1'b0;

    // reset then idle
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_rx_ready", bus.rx_ready_o, 1);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_tx_valid", bus.tx_valid_o, 0);
    check("rst_tx_level", tx_level_o, 0);
    check("rst_rx_level", rx_level_o, 0);

    // TX fill with host stalled, then drain in order
    bus.in_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data_i = 8'(i);
      tick();
    end
    bus.in_valid_i = 1'b0;
    check("tx_full_ready", bus.in_ready_o, 0);
    check("tx_full_level", tx_level_o, 8);
    bus.tx_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("tx_drain_valid", bus.tx_valid_o, 1);
      check("tx_drain_data", bus.tx_data_o, i);
      tick();
    end
    check("tx_empty_valid", bus.tx_valid_o, 0);
    check("tx_empty_level", tx_level_o, 0);
    bus.tx_ready_i = 1'b0;

    // RX streaming with push and pop every cycle across four wraps
    bus.rx_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rx_data_i = 8'hA0 + 8'(i);
      if (i > 0) begin
        check("rx_stream_data", bus.out_data_o, 8'hA0 + 8'(i - 1));
        check("rx_stream_level", rx_level_o, 1);
      end
      tick();
    end
    bus.rx_valid_i = 1'b0;
    check("rx_stream_last", bus.out_data_o, 8'hBF);
    check("rx_stream_lvl_last", rx_level_o, 1);
    tick();
    check("rx_stream_empty", bus.out_valid_o, 0);

    // RX full, then simultaneous pop and attempted push
    bus.out_ready_i = 1'b0;
    bus.rx_valid_i  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data_i = 8'h10 + 8'(i);
      tick();
    end
    bus.rx_valid_i = 1'b0;
    check("rx_full_ready", bus.rx_ready_o, 0);
    check("rx_full_level", rx_level_o, 8);
    check("rx_full_head", bus.out_data_o, 8'h10);
    bus.rx_data_i   = 8'h99;
    bus.rx_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
    check("rx_after_pop_ready", bus.rx_ready_o, 1);
    check("rx_after_pop_level", rx_level_o, 7);
    for (int i = 1; i < 8; i++) begin
      check("rx_full_drain", bus.out_data_o, 8'h10 + 8'(i));
      tick();
    end
    check("rx_full_empty", bus.out_valid_o, 0);
    bus.out_ready_i = 1'b0;

    // flush beats a same-cycle push
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data_i = 8'hC0 + 8'(i);
      tick();
    end
    check("flush_pre_level", tx_level_o, 3);
    bus.in_data_i = 8'h55;
    flush_i       = 1'b1;
    tick();
    flush_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    check("flush_level", tx_level_o, 0);
    check("flush_valid", bus.tx_valid_o, 0);
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("flush_no_55", bus.tx_valid_o, 0);
      tick();
    end
    bus.in_data_i  = 8'h77;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    check("flush_next_valid", bus.tx_valid_o, 1);
    check("flush_next_data", bus.tx_data_o, 8'h77);
    bus.tx_ready_i = 1'b1;
    tick();
    bus.tx_ready_i = 1'b0;

    // reset mid-operation discards RX contents
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data_i = 8'hE0 + 8'(i);
      tick();
    end
    bus.rx_valid_i = 1'b0;
    check("rstmid_pre_level", rx_level_o, 5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rstmid_valid", bus.out_valid_o, 0);
    check("rstmid_level", rx_level_o, 0);
    bus.rx_data_i  = 8'h3C;
    bus.rx_valid_i = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
    check("rstmid_first_valid", bus.out_valid_o, 1);
    check("rstmid_first_data", bus.out_data_o, 8'h3C);
    check("rstmid_first_level", rx_level_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
